// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply / restoring divide unit producing a 2*WIDTH HI/LO result.
// Optional MULDIV_EARLY_OUT_EN: multiply RUN ends once the shifted multiplier is zero.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]         r_state;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_b;
  logic [CW-1:0]      r_cnt;
  logic               r_is_div;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_div_zero;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  // Operand conditioning: op[0]=1 selects unsigned, so sign bits only count when op[0]=0.
  logic             w_sign_a, w_sign_b;
  logic [WIDTH-1:0] w_abs_a, w_abs_b;

  assign w_sign_a = ~op[0] & a[WIDTH-1];
  assign w_sign_b = ~op[0] & b[WIDTH-1];
  assign w_abs_a  = w_sign_a ? -a : a;
  assign w_abs_b  = w_sign_b ? -b : b;

  // Multiply step: multiplicand shifts left, so the product never needs realignment.
  logic [2*WIDTH-1:0] w_prod_next;
  assign w_prod_next = r_acc + (r_b[0] ? r_mcand : '0);

  // Divide step: r_acc holds remainder:quotient; the remainder is always below the divisor.
  logic [WIDTH:0]     w_rem_sh;
  logic               w_ge;
  logic [WIDTH-1:0]   w_rem_next;
  logic [2*WIDTH-1:0] w_div_next;

  assign w_rem_sh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_ge       = w_rem_sh >= {1'b0, r_b};
  assign w_rem_next = w_ge ? (w_rem_sh[WIDTH-1:0] - r_b) : w_rem_sh[WIDTH-1:0];
  assign w_div_next = {w_rem_next, r_acc[WIDTH-2:0], w_ge};

  logic w_last;
`ifdef MULDIV_EARLY_OUT_EN
  assign w_last = r_is_div ? (r_cnt == LAST) : ((r_b >> 1) == '0);
`else
  assign w_last = (r_cnt == LAST);
`endif

  // Sign fix-up applied to magnitudes after the last iteration.
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quot, w_rem, w_quot_fix, w_rem_fix;

  assign w_prod_fix = r_neg_q ? -r_acc : r_acc;
  assign w_quot     = r_acc[WIDTH-1:0];
  assign w_rem      = r_acc[2*WIDTH-1:WIDTH];
  assign w_quot_fix = r_neg_q ? -w_quot : w_quot;
  assign w_rem_fix  = r_neg_r ? -w_rem : w_rem;

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_acc      <= '0;
      r_mcand    <= '0;
      r_b        <= '0;
      r_cnt      <= '0;
      r_is_div   <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_div_zero <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_is_div <= op[1];
            r_neg_q  <= w_sign_a ^ w_sign_b;
            r_neg_r  <= w_sign_a;
            r_cnt    <= '0;
            r_b      <= w_abs_b;
            if (op[1]) begin
              r_acc   <= {{WIDTH{1'b0}}, w_abs_a};
              r_mcand <= '0;
            end else begin
              r_acc   <= '0;
              r_mcand <= {{WIDTH{1'b0}}, w_abs_a};
            end
            if (op[1] && (b == '0)) begin
              r_div_zero <= 1'b1;
              r_state    <= S_DONE;
            end else begin
              r_state    <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (r_is_div) begin
            r_acc <= w_div_next;
          end else begin
            r_acc   <= w_prod_next;
            r_mcand <= r_mcand << 1;
            r_b     <= r_b >> 1;
          end
          r_cnt <= r_cnt + CW'(1);
          if (w_last) r_state <= S_FIX;
        end
        S_FIX: begin
          if (r_is_div) begin
            r_hi <= w_rem_fix;
            r_lo <= w_quot_fix;
          end else begin
            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
            r_lo <= w_prod_fix[WIDTH-1:0];
          end
          r_state <= S_DONE;
        end
        default: begin
          r_div_zero <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  assign hi       = r_hi;
  assign lo       = r_lo;
  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_DONE);
  assign div_zero = r_div_zero;

endmodule
